// File: rtl/direction_input_pkg.sv
// Shared direction encodings and helpers for the snake direction front end.
// The snake datapath decodes headings with the same values.
package direction_input_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // Bit positions of each key within key_n.
    localparam int KEY_RIGHT = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_LEFT  = 3;

    // Inverting both bits swaps right<->left and down<->up.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b11;
    endfunction

    // One-hot heading as {left, up, down, right}.
    function automatic logic [3:0] dir_onehot(input logic [1:0] d);
        logic [3:0] oh;
        case (d)
            DIR_RIGHT: oh = 4'b0001;
            DIR_DOWN:  oh = 4'b0010;
            DIR_UP:    oh = 4'b0100;
            DIR_LEFT:  oh = 4'b1000;
            default:   oh = 4'b0001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/direction_input_key_debounce.sv
// One active-low key: 2-flop synchroniser, stability-counter debouncer and a
// registered pulse on each debounced released->pressed transition.
module key_debounce
    import direction_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_nxt_s;
    logic             press_nxt_s;

    // Debounce counter: runs only while the synced level disagrees with the debounced one.
    always_comb begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        level_nxt_s = level_r;
        press_nxt_s = 1'b0;
        if (sync2_r == level_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            level_nxt_s = sync2_r;
            press_nxt_s = sync2_r;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Synchroniser and debouncer state; levels are stored as 1 = pressed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= ~key_n;
            sync2_r <= sync1_r;
            level_r <= level_nxt_s;
            press_r <= press_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/direction_input.sv
// Snake direction front end: debounced key presses are prioritised, checked
// against the committed heading, held pending and committed on move_tick.
module direction_input
    import direction_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] key_n,
    input  logic       move_tick,
    input  logic       clear,
    output logic [1:0] dir,
    output logic       move_right,
    output logic       move_down,
    output logic       move_up,
    output logic       move_left,
    output logic       dir_changed
);

    logic [3:0] press_s;
    logic [1:0] cand_dir_s;
    logic       cand_any_s;
    logic       cand_ok_s;

    logic [1:0] dir_r;
    logic [1:0] pend_dir_r;
    logic       pend_valid_r;
    logic       changed_r;
    logic [3:0] move_r;

    logic [1:0] dir_nxt_s;
    logic [1:0] pend_dir_nxt_s;
    logic       pend_valid_nxt_s;
    logic       changed_nxt_s;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_key (
            .clk    (clk),
            .reset_n(reset_n),
            .key_n  (key_n[i]),
            .press  (press_s[i])
        );
    end

    // Pick one press (up > down > left > right) and reject repeats and reversals.
    always_comb begin
        cand_dir_s = DIR_RIGHT;
        cand_any_s = 1'b1;
        if (press_s[KEY_UP]) begin
            cand_dir_s = DIR_UP;
        end else if (press_s[KEY_DOWN]) begin
            cand_dir_s = DIR_DOWN;
        end else if (press_s[KEY_LEFT]) begin
            cand_dir_s = DIR_LEFT;
        end else if (press_s[KEY_RIGHT]) begin
            cand_dir_s = DIR_RIGHT;
        end else begin
            cand_dir_s = DIR_RIGHT;
            cand_any_s = 1'b0;
        end
        cand_ok_s = cand_any_s && (cand_dir_s != dir_r) && (cand_dir_s != opposite_dir(dir_r));
    end

    // Pending/commit: a press coinciding with the tick beats whatever was pending.
    always_comb begin
        dir_nxt_s        = dir_r;
        pend_dir_nxt_s   = pend_dir_r;
        pend_valid_nxt_s = pend_valid_r;
        changed_nxt_s    = 1'b0;
        if (clear) begin
            dir_nxt_s        = DIR_RIGHT;
            pend_valid_nxt_s = 1'b0;
        end else if (move_tick) begin
            pend_valid_nxt_s = 1'b0;
            if (cand_ok_s) begin
                dir_nxt_s = cand_dir_s;
            end else if (pend_valid_r) begin
                dir_nxt_s = pend_dir_r;
            end else begin
                dir_nxt_s = dir_r;
            end
            changed_nxt_s = (dir_nxt_s != dir_r);
        end else if (cand_ok_s) begin
            pend_dir_nxt_s   = cand_dir_s;
            pend_valid_nxt_s = 1'b1;
        end else begin
            pend_valid_nxt_s = pend_valid_r;
        end
    end

    // Heading state; move_* are registered from the next heading so they track dir exactly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dir_r        <= DIR_RIGHT;
            pend_dir_r   <= DIR_RIGHT;
            pend_valid_r <= 1'b0;
            changed_r    <= 1'b0;
            move_r       <= 4'b0001;
        end else begin
            dir_r        <= dir_nxt_s;
            pend_dir_r   <= pend_dir_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            changed_r    <= changed_nxt_s;
            move_r       <= dir_onehot(dir_nxt_s);
        end
    end

    assign dir         = dir_r;
    assign dir_changed = changed_r;
    assign move_right  = move_r[0];
    assign move_down   = move_r[1];
    assign move_up     = move_r[2];
    assign move_left   = move_r[3];

endmodule
